// File: rtl/nios_system2_processor1_cpu_debug_mem_pkg.sv
// Shared types and JTAG data-word field positions for the CPU debug-memory arbiter.
package nios_system2_processor1_cpu_debug_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // The jdo word carries a load flag, an 8-bit address and a read flag for ocimem_a,
    // and a 32-bit write payload for ocimem_b.
    localparam int JDO_W         = 38;
    localparam int JDO_LOAD_BIT  = 35;
    localparam int JDO_ADDR_LSB  = 26;
    localparam int JDO_ADDR_W    = 8;
    localparam int JDO_READ_BIT  = 25;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_CRD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } cmd_kind_e;

    // Resolves simultaneous JTAG pulses: ocimem_b beats ocimem_a beats no_action.
    function automatic cmd_kind_e decode_cmd(input logic pulse_b, input logic pulse_a,
                                             input logic a_read, input logic pulse_na);
        if (pulse_b) return CMD_WRITE;
        if (pulse_a) return a_read ? CMD_READ : CMD_NONE;
        if (pulse_na) return CMD_READ;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/nios_system2_processor1_cpu_debug_mem_cmd_latch.sv
// Captures JTAG monitor pulses into a single pending command, owns MonAReg and the
// sticky overrun flag. A command completes when the arbiter raises cmd_done.
module nios_system2_processor1_cpu_debug_mem_cmd_latch
    import nios_system2_processor1_cpu_debug_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              cmd_done,
    output logic              jtag_pend,
    output logic              cmd_is_write,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] mon_a_reg,
    output logic              jtag_overrun
);

    logic              pend_q, pend_d;
    cmd_kind_e         kind_q, kind_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic              ovr_q, ovr_d;

    logic      any_pulse;
    logic      load_addr;
    cmd_kind_e kind_w;
    logic      unused_jdo;

    assign any_pulse = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign kind_w    = decode_cmd(take_action_ocimem_b, take_action_ocimem_a,
                                  jdo[JDO_READ_BIT], take_no_action_ocimem_a);
    // An address load only happens when ocimem_a is the winning pulse.
    assign load_addr = take_action_ocimem_a & ~take_action_ocimem_b & jdo[JDO_LOAD_BIT];
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_LOAD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    always_comb begin
        pend_d  = pend_q;
        kind_d  = kind_q;
        wdata_d = wdata_q;
        mon_a_d = mon_a_q;
        ovr_d   = ovr_q;
        if (cmd_done) begin
            pend_d  = 1'b0;
            mon_a_d = mon_a_q + ADDR_W'(1);
        end
        // cmd_done is only ever raised while pend_q is set, so the two branches never collide.
        if (any_pulse) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                if (load_addr) begin
                    mon_a_d = ADDR_W'(jdo[JDO_ADDR_LSB +: JDO_ADDR_W]);
                end
                case (kind_w)
                    CMD_WRITE: begin
                        pend_d  = 1'b1;
                        kind_d  = CMD_WRITE;
                        wdata_d = DATA_W'(jdo[JDO_WDATA_LSB +: JDO_WDATA_W]);
                    end
                    CMD_READ: begin
                        pend_d = 1'b1;
                        kind_d = CMD_READ;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= 1'b0;
            kind_q  <= CMD_NONE;
            wdata_q <= '0;
            mon_a_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            kind_q  <= kind_d;
            wdata_q <= wdata_d;
            mon_a_q <= mon_a_d;
            ovr_q   <= ovr_d;
        end
    end

    assign jtag_pend    = pend_q;
    assign cmd_is_write = (kind_q == CMD_WRITE);
    assign cmd_wdata    = wdata_q;
    assign mon_a_reg    = mon_a_q;
    assign jtag_overrun = ovr_q;

endmodule

// File: rtl/nios_system2_processor1_cpu_debug_mem_arbiter.sv
// Shares the OCI debug RAM between JTAG monitor commands and CPU debug-slave accesses.
// A pending JTAG command always wins in IDLE; reads spend one extra state on RAM latency.
module nios_system2_processor1_cpu_debug_mem_arbiter
    import nios_system2_processor1_cpu_debug_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_no_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic [JDO_W-1:0]      jdo,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_W-1:0]     cpu_writedata,
    input  logic [DATA_W/8-1:0]   cpu_byteenable,
    input  logic                  cpu_debugaccess,
    output logic [DATA_W-1:0]     cpu_readdata,
    output logic                  cpu_waitrequest,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_wren,
    output logic [DATA_W/8-1:0]   ram_byteen,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic [DATA_W-1:0]     MonDReg,
    output logic                  jtag_overrun,
    output logic [1:0]            dbg_state
);

    state_e            state_q;
    logic [DATA_W-1:0] mon_d_q;

    logic              jtag_pend;
    logic              cmd_is_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] mon_a_reg;
    logic              cmd_done;

    nios_system2_processor1_cpu_debug_mem_cmd_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmd_latch (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .cmd_done                (cmd_done),
        .jtag_pend               (jtag_pend),
        .cmd_is_write            (cmd_is_write),
        .cmd_wdata               (cmd_wdata),
        .mon_a_reg               (mon_a_reg),
        .jtag_overrun            (jtag_overrun)
    );

    // A JTAG write finishes in its IDLE grant cycle; a JTAG read finishes in JRD.
    assign cmd_done = ~reset & (((state_q == ST_IDLE) & jtag_pend & cmd_is_write)
                                | (state_q == ST_JRD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mon_d_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (jtag_pend) begin
                        if (!cmd_is_write) state_q <= ST_JRD;
                    end else if (cpu_read) begin
                        state_q <= ST_CRD;
                    end
                end
                ST_JRD: begin
                    mon_d_q <= ram_rdata;
                    state_q <= ST_IDLE;
                end
                ST_CRD:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // cpu_read/cpu_write are the CPU's valid and stay high until the access completes;
    // completion is the cycle cpu_waitrequest is low. A write completes in IDLE, a read in CRD.
    always_comb begin
        ram_addr        = mon_a_reg;
        ram_wren        = 1'b0;
        ram_byteen      = '1;
        ram_wdata       = cmd_wdata;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = '0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (jtag_pend) begin
                        ram_wren = cmd_is_write;
                    end else if (cpu_read) begin
                        ram_addr = cpu_address;
                    end else if (cpu_write) begin
                        ram_addr        = cpu_address;
                        ram_wdata       = cpu_writedata;
                        ram_byteen      = cpu_byteenable;
                        ram_wren        = cpu_debugaccess;
                        cpu_waitrequest = 1'b0;
                    end
                end
                ST_CRD: begin
                    cpu_readdata    = ram_rdata;
                    cpu_waitrequest = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign MonDReg   = mon_d_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nios_system2_processor1_cpu_debug_mem_arbiter.sv
// Bench for the debug-memory arbiter: directed scenarios with literal expectations, then
// random JTAG/CPU traffic checked every cycle against a transaction-level model.
module tb_nios_system2_processor1_cpu_debug_mem_arbiter;
    import nios_system2_processor1_cpu_debug_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [37:0] jdo = '0;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [3:0]  cpu_byteenable = '0;
    logic        cpu_debugaccess = 1'b0;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        jtag_overrun;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    nios_system2_processor1_cpu_debug_mem_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_debugaccess         (cpu_debugaccess),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteen              (ram_byteen),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_overrun            (jtag_overrun),
        .dbg_state               (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- OCI RAM: one-cycle synchronous read ----------------
    logic [31:0] ram_mem [256];

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b = 8'(i);
        return {b, ~b, 8'hC3, b};
    endfunction

    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr];
        if (ram_wren)
            for (int i = 0; i < 4; i++)
                if (ram_byteen[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [256];
    bit          m_pend, m_wr, m_ovr;
    logic [31:0] m_wdata, m_d, m_rd_val;
    logic [7:0]  m_a;
    int          m_busy;          // 0 nothing in flight, 1 JTAG read data due, 2 CPU read data due
    bit          acc_seen;

    always @(negedge clk) begin
        logic [7:0]  e_addr;
        logic        e_wren, e_wait;
        logic [31:0] e_wdata, e_rdata, old_d;
        logic [3:0]  e_be;
        bit          old_pend, old_ovr;
        int          nxt_busy;
        acc_seen = !cpu_waitrequest && (cpu_read || cpu_write);
        if (reset) begin
            m_pend = 0; m_wr = 0; m_ovr = 0; m_d = '0; m_a = '0; m_busy = 0;
            chk("rst_wren", ram_wren, 0);
            chk("rst_wait", cpu_waitrequest, 1);
            chk("rst_rdata", cpu_readdata, 0);
            chk("rst_mond", MonDReg, 0);
            chk("rst_ovr", jtag_overrun, 0);
            chk("rst_addr", ram_addr, 0);
        end else begin
            old_pend = m_pend; old_ovr = m_ovr; old_d = m_d;
            e_addr = m_a; e_wren = 0; e_wdata = m_wdata; e_be = 4'hF;
            e_wait = 1; e_rdata = '0; nxt_busy = 0;
            if (m_busy == 1) begin
                m_d = m_rd_val; m_a = m_a + 8'd1; m_pend = 0;
            end else if (m_busy == 2) begin
                e_wait = 0; e_rdata = m_rd_val;
            end else if (m_pend && m_wr) begin
                e_wren = 1; mem_m[m_a] = m_wdata; m_a = m_a + 8'd1; m_pend = 0;
            end else if (m_pend) begin
                m_rd_val = mem_m[m_a]; nxt_busy = 1;
            end else if (cpu_read) begin
                e_addr = cpu_address; m_rd_val = mem_m[cpu_address]; nxt_busy = 2;
            end else if (cpu_write) begin
                e_addr = cpu_address; e_wdata = cpu_writedata; e_be = cpu_byteenable;
                e_wren = cpu_debugaccess; e_wait = 0;
                if (cpu_debugaccess)
                    for (int i = 0; i < 4; i++)
                        if (cpu_byteenable[i]) mem_m[cpu_address][8*i +: 8] = cpu_writedata[8*i +: 8];
            end
            if (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b) begin
                if (old_pend) m_ovr = 1;
                else if (take_action_ocimem_b) begin
                    m_pend = 1; m_wr = 1; m_wdata = jdo[34:3];
                end else if (take_action_ocimem_a) begin
                    if (jdo[35]) m_a = jdo[33:26];
                    if (jdo[25]) begin m_pend = 1; m_wr = 0; end
                end else begin
                    m_pend = 1; m_wr = 0;
                end
            end
            m_busy = nxt_busy;
            chk("wren", ram_wren, e_wren);
            chk("addr", ram_addr, e_addr);
            chk("waitreq", cpu_waitrequest, e_wait);
            chk("readdata", cpu_readdata, e_rdata);
            chk("mondreg", MonDReg, old_d);
            chk("overrun", jtag_overrun, old_ovr);
            if (e_wren) begin
                chk("wdata", ram_wdata, e_wdata);
                chk("byteen", ram_byteen, e_be);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input bit load, input logic [7:0] addr, input bit rd);
        logic [37:0] j = '0;
        j[35] = load; j[33:26] = addr; j[25] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic pulse(input bit a, input bit na, input bit b, input logic [37:0] j);
        take_action_ocimem_a = a; take_no_action_ocimem_a = na; take_action_ocimem_b = b; jdo = j;
        @(posedge clk); #1;
        take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    endtask

    task automatic cpu_access(input bit rd, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] be, input bit dbg,
                              output logic [31:0] rdata, output int waits);
        cpu_read = rd; cpu_write = !rd; cpu_address = a; cpu_writedata = d;
        cpu_byteenable = be; cpu_debugaccess = dbg;
        waits = 0; rdata = '0;
        while (1) begin
            @(negedge clk);
            if (!cpu_waitrequest) begin rdata = cpu_readdata; break; end
            waits++;
            if (waits > 20) begin chk("cpu_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        cpu_read = 0; cpu_write = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        int          w;
        bit          cpu_active;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = init_word(i);
            mem_m[i]   = init_word(i);
        end
        ram_mem[8'h10] = 32'hDEADBEEF;
        mem_m[8'h10]   = 32'hDEADBEEF;
        tick(3);
        reset = 0;
        tick(1);

        // JTAG address load + read of 0x10
        pulse(1, 0, 0, jdo_a(1, 8'h10, 1));
        tick(2);
        @(negedge clk);
        chk("t1_mondreg", MonDReg, 32'hDEADBEEF);
        chk("t1_monareg", ram_addr, 8'h11);
        tick(1);

        // JTAG write at 0xFF wraps MonAReg to 0
        pulse(1, 0, 0, jdo_a(1, 8'hFF, 0));
        pulse(0, 0, 1, jdo_b(32'h12345678));
        tick(1);
        @(negedge clk);
        chk("t2_ram_ff", ram_mem[8'hFF], 32'h12345678);
        chk("t2_monareg_wrap", ram_addr, 8'h00);
        tick(1);

        // CPU read races a pending JTAG write to the same word
        pulse(1, 0, 0, jdo_a(1, 8'h20, 0));
        pulse(0, 0, 1, jdo_b(32'h55));
        cpu_access(1, 8'h20, '0, 4'hF, 0, rd, w);
        chk("t3_readdata", rd, 32'h55);
        chk("t3_waits", w, 2);

        // CPU writes qualified by debugaccess
        cpu_access(0, 8'h05, 32'hAAAA5555, 4'hF, 0, rd, w);
        chk("t4_nodbg_waits", w, 0);
        chk("t4_nodbg_ram", ram_mem[8'h05], 32'h05FAC305);
        cpu_access(0, 8'h05, 32'hAAAA5555, 4'hF, 1, rd, w);
        chk("t4_dbg_waits", w, 0);
        chk("t4_dbg_ram", ram_mem[8'h05], 32'hAAAA5555);

        // Overrun: second pulse one cycle after a read pulse
        reset = 1; tick(2); reset = 0; tick(1);
        pulse(0, 1, 0, '0);
        pulse(0, 1, 0, '0);
        @(negedge clk);
        chk("t5_overrun", jtag_overrun, 1);
        tick(30);
        @(negedge clk);
        chk("t5_overrun_sticky", jtag_overrun, 1);
        chk("t5_mondreg", MonDReg, 32'h00FFC300);
        tick(1);

        // Reset while a JTAG read sits in JRD
        pulse(0, 1, 0, '0);
        tick(1);
        @(negedge clk);
        chk("t6_in_jrd", dbg_state, ST_JRD);
        #1 reset = 1;
        @(negedge clk);
        chk("t6_mond_cleared", MonDReg, 0);
        chk("t6_no_wren", ram_wren, 0);
        @(posedge clk); #1 reset = 0;
        tick(1);
        @(negedge clk);
        chk("t6_idle", dbg_state, ST_IDLE);
        chk("t6_mond_zero", MonDReg, 0);
        chk("t6_ram_intact", ram_mem[8'h01], 32'h01FEC301);
        tick(1);

        // Random traffic
        cpu_active = 0;
        for (int c = 0; c < 4000; c++) begin
            take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
            if ($urandom_range(0, 99) < 15) begin
                take_action_ocimem_a    = 1'($urandom_range(0, 1));
                take_no_action_ocimem_a = 1'($urandom_range(0, 1));
                take_action_ocimem_b    = 1'($urandom_range(0, 1));
                jdo = {6'($urandom), $urandom};
            end
            if (cpu_active && acc_seen) begin
                cpu_read = 0; cpu_write = 0; cpu_active = 0;
            end
            if (!cpu_active && $urandom_range(0, 99) < 40) begin
                cpu_read        = 1'($urandom_range(0, 1));
                cpu_write       = !cpu_read || ($urandom_range(0, 9) == 0);
                cpu_address     = 8'($urandom);
                cpu_writedata   = $urandom;
                cpu_byteenable  = 4'($urandom);
                cpu_debugaccess = ($urandom_range(0, 3) != 0);
                cpu_active      = 1;
            end
            reset = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
        cpu_read = 0; cpu_write = 0; reset = 0;
        tick(4);
        for (int i = 0; i < 256; i++) chk("final_mem", ram_mem[i], mem_m[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        chk("watchdog", 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_system2_processor1_cpu_debug_mem_arbiter.md
NIOS_SYSTEM2_PROCESSOR1_CPU_DEBUG_MEM_ARBITER -- requirements
Module: nios_system2_processor1_cpu_debug_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the OCI RAM word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the OCI RAM data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 take_action_ocimem_a  in  1  SHALL be a one-cycle JTAG pulse: address load and/or read command.
REQ-006 take_no_action_ocimem_a  in  1  SHALL be a one-cycle JTAG pulse: read at current address.
REQ-007 take_action_ocimem_b  in  1  SHALL be a one-cycle JTAG pulse: write at current address.
REQ-008 jdo  in  38  SHALL be the JTAG data word, valid only in a pulse cycle.
REQ-009 cpu_address  in  ADDR_W  SHALL be the CPU word address.
REQ-010 cpu_read  in  1  SHALL be the CPU read request, held until accepted.
REQ-011 cpu_write  in  1  SHALL be the CPU write request, held until accepted.
REQ-012 cpu_writedata  in  DATA_W  SHALL be the CPU write data.
REQ-013 cpu_byteenable  in  DATA_W/8  SHALL be the CPU byte enables.
REQ-014 cpu_debugaccess  in  1  SHALL qualify CPU writes (debug-mode access).
REQ-015 cpu_readdata  out  DATA_W  SHALL be the CPU read data.
REQ-016 cpu_waitrequest  out  1  SHALL stall the CPU while high.
REQ-017 ram_addr  out  ADDR_W  SHALL be the OCI RAM address.
REQ-018 ram_wren  out  1  SHALL be the OCI RAM write enable.
REQ-019 ram_byteen  out  DATA_W/8  SHALL be the OCI RAM byte enables.
REQ-020 ram_wdata  out  DATA_W  SHALL be the OCI RAM write data.
REQ-021 ram_rdata  in  DATA_W  SHALL be the OCI RAM read data, one-cycle synchronous latency.
REQ-022 MonDReg  out  DATA_W  SHALL be the JTAG read-data register.
REQ-023 jtag_overrun  out  1  SHALL be a sticky dropped-command flag.

Function
REQ-024 A pulse while jtag_pend=0 SHALL set jtag_pend and latch the command. ocimem_b: write, data jdo[34:3]. no_action: read. ocimem_a: jdo[35]=1 loads MonAReg=jdo[33:26] on the same edge; jdo[25]=1 queues a read; jdo[25]=0 leaves jtag_pend clear.
REQ-025 Simultaneous pulses SHALL resolve b > a > no_action; only the winner is captured; jtag_overrun unaffected.
REQ-026 A pulse while jtag_pend=1 SHALL be dropped, including any MonAReg load, and SHALL set jtag_overrun.
REQ-027 FSM states SHALL be IDLE, JRD, CRD; in IDLE, jtag_pend SHALL win over a same-cycle CPU request.
REQ-028 IDLE with a pending write: ram_wren=1, ram_addr=MonAReg, ram_wdata=latched data, ram_byteen all ones; next edge clears jtag_pend, increments MonAReg, stays IDLE.
REQ-029 IDLE with a pending read: ram_addr=MonAReg, go JRD. JRD: MonDReg<=ram_rdata, MonAReg+1, jtag_pend cleared, go IDLE.
REQ-030 IDLE, no pending, cpu_write=1 (cpu_read=0): drive CPU address/data/byteenable, ram_wren=cpu_debugaccess, cpu_waitrequest=0 that cycle, stay IDLE.
REQ-031 IDLE, no pending, cpu_read=1: ram_addr=cpu_address, go CRD. CRD: cpu_readdata=ram_rdata, cpu_waitrequest=0, go IDLE. Reads SHALL ignore cpu_debugaccess.
REQ-032 cpu_read and cpu_write both high SHALL be treated as a read; the write is not performed.
REQ-033 cpu_waitrequest SHALL be 1, and cpu_readdata 0, in every cycle not covered by REQ-030/031.
REQ-034 ram_wren SHALL be 0 outside REQ-028/030; ram_addr SHALL be MonAReg when no access is active.
REQ-035 MonAReg SHALL increment modulo 2^ADDR_W (0xFF->0x00).
REQ-036 A pending JTAG command SHALL be granted within 2 cycles of capture.

Reset
REQ-037 reset high SHALL force state IDLE, jtag_pend=0, MonAReg=0, MonDReg=0, jtag_overrun=0, cpu_waitrequest=1, ram_wren=0, cpu_readdata=0.
REQ-038 Reset mid-operation SHALL abandon the operation with no RAM write once reset is high; the CPU reissues.

Structure
REQ-039 Package nios_system2_processor1_cpu_debug_mem_pkg SHALL hold the state enum, command-kind enum, jdo field positions and the ADDR_W/DATA_W defaults.
REQ-040 Sub-module nios_system2_processor1_cpu_debug_mem_cmd_latch SHALL hold pulse capture, priority, jtag_pend, jtag_overrun and MonAReg.

Verification
REQ-041 RAM[0x10]=0xDEADBEEF; ocimem_a with jdo[35]=1, addr 0x10, jdo[25]=1 -> MonDReg=0xDEADBEEF two edges after grant; MonAReg=0x11.
REQ-042 MonAReg=0xFF; ocimem_b with data 0x12345678 -> RAM[0xFF]=0x12345678; MonAReg=0x00.
REQ-043 cpu_read 0x20 in the same cycle as a pending JTAG write of 0x55 to 0x20 -> write first; cpu_readdata=0x55; waitrequest high one extra cycle.
REQ-044 cpu_write 0x05 <- 0xAAAA5555: with debugaccess=0 -> waitrequest=0 that cycle, RAM unchanged; with debugaccess=1 -> RAM updated.
REQ-045 Second pulse one cycle after a read pulse -> second dropped; jtag_overrun=1 until reset.
REQ-046 reset asserted in JRD -> MonDReg=0, no RAM write, IDLE after release.
